// File: rtl/branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// branch_resolve_ctrl
//
// Control-flow recovery around the execute-stage branch condition unit.
// Keeps a bimodal branch history table (BHT) of 2-bit saturating counters,
// supplies a combinational taken/not-taken prediction to fetch, and checks
// each resolved conditional branch against the prediction carried down the
// pipe. A mispredict starts a flush/redirect sequence that squashes younger
// instructions and steers fetch to the corrected PC.
//
// Optional feature macro: BRANCH_RESOLVE_PERF_EN
//   When defined, adds 32-bit wrapping counters of accepted resolutions
//   (perf_branches) and of mispredicts (perf_mispredicts).
//
// Ports:
//   clk              in   system clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   pred_pc          in   fetch-stage PC to predict
//   pred_taken       out  prediction for pred_pc (counter MSB), combinational
//   res_valid        in   execute stage holds a valid instruction
//   res_is_branch    in   instruction is a conditional branch
//   res_pc           in   PC of the resolving instruction
//   res_taken        in   actual outcome from the branch condition unit
//   res_pred_taken   in   prediction made at fetch, piped down
//   res_target       in   computed branch target
//   res_next_pc      in   fall-through PC
//   flush            out  squash IF/ID/EX younger instructions
//   redirect_valid   out  one-cycle pulse, fetch loads redirect_pc
//   redirect_pc      out  corrected fetch address
//   busy             out  recovery in progress, resolutions ignored
//   perf_branches    out  accepted resolutions   (BRANCH_RESOLVE_PERF_EN only)
//   perf_mispredicts out  mispredicts            (BRANCH_RESOLVE_PERF_EN only)
// ---------------------------------------------------------------------------
module branch_resolve_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned BHT_IDX_W    = 6,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pred_pc,
    output logic            pred_taken,
    input  logic            res_valid,
    input  logic            res_is_branch,
    input  logic [XLEN-1:0] res_pc,
    input  logic            res_taken,
    input  logic            res_pred_taken,
    input  logic [XLEN-1:0] res_target,
    input  logic [XLEN-1:0] res_next_pc,
    output logic            flush,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
`ifdef BRANCH_RESOLVE_PERF_EN
    output logic [31:0]     perf_branches,
    output logic [31:0]     perf_mispredicts,
`endif
    output logic            busy
);

    localparam int unsigned BhtEntries = 1 << BHT_IDX_W;
    localparam logic [1:0]  CtrReset   = 2'b01;   // weakly not-taken
    localparam logic [3:0]  FlushLast  = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [0:0] {
        StIdle,
        StFlush
    } state_e;

    state_e                 state_q, state_d;
    logic [3:0]             flush_cnt_q, flush_cnt_d;
    logic                   redirect_valid_q;
    logic [XLEN-1:0]        redirect_pc_q, redirect_pc_d;
    logic [1:0]             bht_q [BhtEntries];

    logic [BHT_IDX_W-1:0]   pred_idx;
    logic [BHT_IDX_W-1:0]   res_idx;
    logic [1:0]             res_ctr;
    logic [1:0]             res_ctr_upd;
    logic                   accept;
    logic                   mispredict;

    // Only the word-index bits of the PCs address the table.
    logic                   unused_pc_bits;
    assign unused_pc_bits = ^{pred_pc[XLEN-1:BHT_IDX_W+2], pred_pc[1:0],
                              res_pc[XLEN-1:BHT_IDX_W+2], res_pc[1:0]};

    // ---------------------------------------------------------------------
    // Prediction: plain table read, no bypass of a same-cycle update.
    // ---------------------------------------------------------------------
    assign pred_idx   = pred_pc[BHT_IDX_W+1:2];
    assign pred_taken = bht_q[pred_idx][1];

    // ---------------------------------------------------------------------
    // Resolution
    // ---------------------------------------------------------------------
    assign res_idx    = res_pc[BHT_IDX_W+1:2];
    assign res_ctr    = bht_q[res_idx];
    assign accept     = res_valid && res_is_branch && (state_q == StIdle);
    assign mispredict = accept && (res_taken != res_pred_taken);

    always_comb begin
        res_ctr_upd = res_ctr;
        if (res_taken) begin
            if (res_ctr != 2'b11) begin
                res_ctr_upd = res_ctr + 2'b01;
            end
        end else begin
            if (res_ctr != 2'b00) begin
                res_ctr_upd = res_ctr - 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BhtEntries; i++) begin
                bht_q[i] <= CtrReset;
            end
        end else if (accept) begin
            bht_q[res_idx] <= res_ctr_upd;
        end
    end

    // ---------------------------------------------------------------------
    // Flush / redirect FSM
    // ---------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        redirect_pc_d = redirect_pc_q;
        unique case (state_q)
            StIdle: begin
                if (mispredict) begin
                    state_d       = StFlush;
                    // Counts the remaining flush cycles after this entry edge.
                    flush_cnt_d   = FlushLast;
                    redirect_pc_d = res_taken ? res_target : res_next_pc;
                end
            end
            StFlush: begin
                if (flush_cnt_q == 4'd0) begin
                    state_d = StIdle;
                end else begin
                    flush_cnt_d = flush_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d     = StIdle;
                flush_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            flush_cnt_q      <= 4'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            // Mispredicts are only taken in IDLE, so this is a single pulse.
            redirect_valid_q <= mispredict;
            redirect_pc_q    <= redirect_pc_d;
        end
    end

    assign flush          = (state_q == StFlush);
    assign busy           = (state_q == StFlush);
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;

`ifdef BRANCH_RESOLVE_PERF_EN
    // ---------------------------------------------------------------------
    // Performance counters, free-running with natural 32-bit wrap.
    // ---------------------------------------------------------------------
    logic [31:0] perf_branches_q;
    logic [31:0] perf_mispredicts_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_branches_q    <= 32'd0;
            perf_mispredicts_q <= 32'd0;
        end else begin
            if (accept) begin
                perf_branches_q <= perf_branches_q + 32'd1;
            end
            if (mispredict) begin
                perf_mispredicts_q <= perf_mispredicts_q + 32'd1;
            end
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//
// Self-checking bench for branch_resolve_ctrl. A reference BHT and flush
// model run alongside the DUT; expected redirect PCs are queued when a
// mispredict is driven and popped when redirect_valid is seen.
// ---------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned BHT_IDX_W    = 6;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned Entries      = 1 << BHT_IDX_W;

    logic            clk;
    logic            rst_n;
    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;
    logic            res_valid;
    logic            res_is_branch;
    logic [XLEN-1:0] res_pc;
    logic            res_taken;
    logic            res_pred_taken;
    logic [XLEN-1:0] res_target;
    logic [XLEN-1:0] res_next_pc;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            busy;
`ifdef BRANCH_RESOLVE_PERF_EN
    logic [31:0]     perf_branches;
    logic [31:0]     perf_mispredicts;
`endif

    branch_resolve_ctrl #(
        .XLEN         (XLEN),
        .BHT_IDX_W    (BHT_IDX_W),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .pred_pc          (pred_pc),
        .pred_taken       (pred_taken),
        .res_valid        (res_valid),
        .res_is_branch    (res_is_branch),
        .res_pc           (res_pc),
        .res_taken        (res_taken),
        .res_pred_taken   (res_pred_taken),
        .res_target       (res_target),
        .res_next_pc      (res_next_pc),
        .flush            (flush),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
`ifdef BRANCH_RESOLVE_PERF_EN
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts),
`endif
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [1:0]      m_bht [Entries];
    int              m_flush;
    logic [XLEN-1:0] m_rpc;
    int unsigned     m_br;
    int unsigned     m_mis;
    logic [XLEN-1:0] exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [XLEN-1:0] pc);
        return int'(pc[BHT_IDX_W+1:2]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < Entries; i++) m_bht[i] = 2'b01;
        m_flush = 0;
        m_rpc   = '0;
        m_br    = 0;
        m_mis   = 0;
        exp_q.delete();
    endtask

    task automatic clear_inputs();
        res_valid      = 1'b0;
        res_is_branch  = 1'b0;
        res_pc         = '0;
        res_taken      = 1'b0;
        res_pred_taken = 1'b0;
        res_target     = '0;
        res_next_pc    = '0;
    endtask

    task automatic check_pred(input string tag, input logic [XLEN-1:0] pc);
        pred_pc = pc;
        #1;
        check_eq(tag, 64'(pred_taken), 64'(m_bht[idx_of(pc)][1]));
    endtask

    // One clock with the given resolution inputs, then model update and checks.
    task automatic step(input logic v, input logic br, input logic [XLEN-1:0] pc,
                        input logic tk, input logic ptk,
                        input logic [XLEN-1:0] tgt, input logic [XLEN-1:0] nxt);
        logic acc;
        logic mis;
        int   ix;
        res_valid      = v;
        res_is_branch  = br;
        res_pc         = pc;
        res_taken      = tk;
        res_pred_taken = ptk;
        res_target     = tgt;
        res_next_pc    = nxt;
        acc = v && br && (m_flush == 0);
        mis = acc && (tk != ptk);
        @(posedge clk);
        #1;
        if (m_flush > 0) m_flush--;
        if (acc) begin
            ix = idx_of(pc);
            if (tk && m_bht[ix] != 2'b11) m_bht[ix] = m_bht[ix] + 2'b01;
            if (!tk && m_bht[ix] != 2'b00) m_bht[ix] = m_bht[ix] - 2'b01;
            m_br++;
        end
        if (mis) begin
            exp_q.push_back(tk ? tgt : nxt);
            m_rpc   = tk ? tgt : nxt;
            m_flush = FLUSH_CYCLES;
            m_mis++;
        end
        check_eq("redirect_valid", 64'(redirect_valid), 64'(mis));
        if (redirect_valid) begin
            check_eq("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) check_eq("redirect_pc_sb", 64'(redirect_pc), 64'(exp_q.pop_front()));
        end
        check_eq("redirect_pc_hold", 64'(redirect_pc), 64'(m_rpc));
        check_eq("flush", 64'(flush), 64'(m_flush > 0));
        check_eq("busy", 64'(busy), 64'(m_flush > 0));
        clear_inputs();
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        clear_inputs();
        pred_pc = '0;
        rst_n   = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state
        check_pred("reset_pred_0x100", 32'h100);
        check_eq("reset_flush", 64'(flush), 64'(0));
        check_eq("reset_busy", 64'(busy), 64'(0));
        check_eq("reset_rv", 64'(redirect_valid), 64'(0));
        check_eq("reset_rpc", 64'(redirect_pc), 64'(0));

        // Taken x3 at 0x100: first is a mispredict, then saturate at 11
        step(1, 1, 32'h100, 1, 0, 32'h400, 32'h104);
        idle_step();
        idle_step();
        step(1, 1, 32'h100, 1, 1, 32'h400, 32'h104);
        step(1, 1, 32'h100, 1, 1, 32'h400, 32'h104);
        step(1, 1, 32'h100, 1, 1, 32'h400, 32'h104);
        check_pred("sat_pred_0x100", 32'h100);

        // Not-taken mispredict at 0x200 (aliases index 0), fall-through 0x204
        step(1, 1, 32'h200, 0, 1, 32'h800, 32'h204);
        // In FLUSH: a mispredict at 0x300 must be ignored entirely
        step(1, 1, 32'h300, 0, 1, 32'h900, 32'h304);
        idle_step();
        check_pred("flush_ignored_0x300", 32'h300);

        // Non-branch and invalid: no effect
        step(1, 0, 32'h104, 1, 0, 32'h500, 32'h108);
        step(0, 1, 32'h104, 1, 0, 32'h500, 32'h108);
        check_pred("nonbranch_0x104", 32'h104);

        // Back-to-back: mispredict again as soon as IDLE is re-entered
        step(1, 1, 32'h40, 1, 0, 32'h1000, 32'h44);
        idle_step();
        idle_step();
        step(1, 1, 32'h44, 1, 0, 32'h2000, 32'h48);
        idle_step();
        idle_step();

        // Pseudo-random mix of resolutions
        for (int i = 0; i < 40; i++) begin
            logic [XLEN-1:0] pc;
            pc = XLEN'($urandom_range(0, 255)) << 2;
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), pc,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 XLEN'($urandom), pc + 32'd4);
            check_pred("rand_pred", XLEN'($urandom_range(0, 255)) << 2);
        end

`ifdef BRANCH_RESOLVE_PERF_EN
        check_eq("perf_branches", 64'(perf_branches), 64'(m_br));
        check_eq("perf_mispredicts", 64'(perf_mispredicts), 64'(m_mis));
`endif

        // Reset during the first FLUSH cycle
        idle_step();
        idle_step();
        step(1, 1, 32'h80, 1, 0, 32'h3000, 32'h84);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_flush", 64'(flush), 64'(0));
        check_eq("rst_mid_busy", 64'(busy), 64'(0));
        check_eq("rst_mid_rv", 64'(redirect_valid), 64'(0));
        check_eq("rst_mid_rpc", 64'(redirect_pc), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < Entries; i++) begin
            check_pred("rst_bht_pred", XLEN'(i) << 2);
        end
        // 01 -> 10 on one taken update proves the weakly-not-taken reset value
        step(1, 1, 32'h10, 1, 1, 32'h20, 32'h14);
        check_pred("rst_bht_weak", 32'h10);
        idle_step();
        check_eq("no_stray_redirects", 64'(exp_q.size()), 64'(0));

`ifdef BRANCH_RESOLVE_PERF_EN
        check_eq("perf_branches_post_rst", 64'(perf_branches), 64'(m_br));
        check_eq("perf_mispredicts_post_rst", 64'(perf_mispredicts), 64'(m_mis));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
